// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared mode enum and duty-stepping helper for the LED PWM block.
// Used by led_pwm_multi (mode select) and pwm_channel (fade stepping).
package led_pwm_pkg;
   typedef enum logic {MODE_JUMP, MODE_FADE} mode_e;
   // One fade step: move active one count toward target, or hold when equal.
   function automatic logic [15:0] step_toward(input logic [15:0] active, input logic [15:0] target);
      return (active < target) ? active + 16'd1 : (active > target) ? active - 16'd1 : active;
   endfunction
endpackage

// File: rtl/led_pwm_multi_channel.sv
// pwm_channel: target/active duty pair and registered PWM compare for one LED.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_en             run enable; low blanks the output
//   i_wr, i_wr_duty  write strobe already decoded for this channel, new target
//   i_wrap           period counter wraps this cycle
//   i_fade_step      this wrap is a fade step
//   i_mode           jump or fade update mode
//   i_cnt            shared period counter
//   o_led            registered PWM output
//   o_busy           active duty differs from target
module pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic         i_wr,
   input  logic [W-1:0] i_wr_duty,
   input  logic         i_wrap,
   input  logic         i_fade_step,
   input  mode_e        i_mode,
   input  logic [W-1:0] i_cnt,
   output logic         o_led,
   output logic         o_busy
);
   logic [W-1:0] target;
   logic [W-1:0] active;
   // Nonblocking update means a write landing on the wrap edge is seen only at the next wrap.
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         target <= '0;
         active <= '0;
         o_led  <= 1'b0;
      end else begin
         if (i_wr) target <= i_wr_duty;
         if (i_wrap)
            active <= (i_mode == MODE_JUMP) ? target :
                      i_fade_step ? W'(step_toward(16'(active), 16'(target))) : active;
         o_led <= i_en & (i_cnt < active);
      end
   assign o_busy = active != target;
endmodule

// File: rtl/led_pwm_multi.sv
// led_pwm_multi: multi-channel LED PWM with period-aligned duty updates and optional linear fade.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_en          run enable; low freezes counter/fade state and blanks outputs
//   i_wr          single-cycle duty write strobe
//   i_wr_ch       target channel (out-of-range indices ignored)
//   i_wr_duty     target duty 0..2^W-1
//   i_fade        0 jump to target at wrap, 1 fade one step per FADE_PERIODS wraps
//   o_led         registered PWM outputs, one per channel
//   o_period_end  one-cycle pulse in the cycle cnt==0 after each wrap
//   o_busy        some channel's active duty differs from its target
module led_pwm_multi
   import led_pwm_pkg::*;
#(
   parameter int CH           = 8,
   parameter int W            = 8,
   parameter int FADE_PERIODS = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_en,
   input  logic                              i_wr,
   input  logic [(CH > 1 ? $clog2(CH) : 1)-1:0] i_wr_ch,
   input  logic [W-1:0]                      i_wr_duty,
   input  logic                              i_fade,
   output logic [CH-1:0]                     o_led,
   output logic                              o_period_end,
   output logic                              o_busy
);
   localparam int FW = FADE_PERIODS > 1 ? $clog2(FADE_PERIODS) : 1;
   localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};
   logic [W-1:0]  cnt;
   logic [FW-1:0] fade_cnt;
   logic [CH-1:0] busy;
   logic          wrap;
   logic          fade_step;
   mode_e         mode;
   assign mode      = i_fade ? MODE_FADE : MODE_JUMP;
   assign wrap      = i_en && cnt == LAST;
   assign fade_step = wrap && mode == MODE_FADE && fade_cnt == FW'(FADE_PERIODS - 1);
   assign o_busy    = |busy;
   // Counter runs 0..MAX-1 so a duty of MAX compares high on every cycle.
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         cnt          <= '0;
         fade_cnt     <= '0;
         o_period_end <= 1'b0;
      end else begin
         o_period_end <= wrap;
         if (i_en) begin
            cnt      <= wrap ? '0 : cnt + W'(1);
            fade_cnt <= (mode == MODE_JUMP || fade_step) ? '0 : wrap ? fade_cnt + FW'(1) : fade_cnt;
         end
      end
   for (genvar c = 0; c < CH; c++) begin : g_ch
      pwm_channel #(.W(W)) u_ch (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_en        (i_en),
         .i_wr        (i_wr && 32'(i_wr_ch) == c),
         .i_wr_duty   (i_wr_duty),
         .i_wrap      (wrap),
         .i_fade_step (fade_step),
         .i_mode      (mode),
         .i_cnt       (cnt),
         .o_led       (o_led[c]),
         .o_busy      (busy[c])
      );
   end
endmodule

// File: tb/tb_led_pwm_multi.sv
// tb_led_pwm_multi: directed and random checks of led_pwm_multi against a cycle reference model.
module tb_led_pwm_multi;
   localparam int CH = 6, W = 8, FP = 4, MAX = 255;
   logic          clk = 1'b0;
   logic          rst, en, wr, fade;
   logic [2:0]    wr_ch;
   logic [W-1:0]  wr_duty;
   logic [CH-1:0] led;
   logic          pend, busy;
   int            n_chk = 0, n_fail = 0;
   int            m_cnt, m_fcnt;
   int            m_tgt[CH], m_act[CH];
   logic [CH-1:0] m_led;
   logic          m_pend;

   always #5 clk = ~clk;

   led_pwm_multi #(.CH(CH), .W(W), .FADE_PERIODS(FP)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_wr(wr), .i_wr_ch(wr_ch),
      .i_wr_duty(wr_duty), .i_fade(fade), .o_led(led), .o_period_end(pend), .o_busy(busy)
   );

   function automatic void m_reset();
      m_cnt = 0; m_fcnt = 0; m_led = '0; m_pend = 1'b0;
      for (int c = 0; c < CH; c++) begin m_tgt[c] = 0; m_act[c] = 0; end
   endfunction

   function automatic logic m_busy();
      logic b = 1'b0;
      for (int c = 0; c < CH; c++) b |= m_act[c] != m_tgt[c];
      return b;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: one clock edge using the inputs presented this cycle.
   task automatic m_clock();
      logic w;
      w = en && m_cnt == MAX - 1;
      for (int c = 0; c < CH; c++) m_led[c] = en && (m_cnt < m_act[c]);
      m_pend = w;
      if (w) begin
         if (!fade) for (int c = 0; c < CH; c++) m_act[c] = m_tgt[c];
         else if (m_fcnt == FP - 1) begin
            for (int c = 0; c < CH; c++)
               m_act[c] += (m_act[c] < m_tgt[c]) ? 1 : (m_act[c] > m_tgt[c]) ? -1 : 0;
            m_fcnt = 0;
         end else m_fcnt++;
      end
      if (en && !fade) m_fcnt = 0;
      if (en) m_cnt = w ? 0 : m_cnt + 1;
      if (wr && wr_ch < CH) m_tgt[wr_ch] = int'(wr_duty);
   endtask

   task automatic tick();
      @(posedge clk);
      m_clock();
      #1;
      check("led", 32'(led), 32'(m_led));
      check("period_end", 32'(pend), 32'(m_pend));
      check("busy", 32'(busy), 32'(m_busy()));
   endtask

   task automatic write(input int ch, input int d);
      wr = 1'b1; wr_ch = 3'(ch); wr_duty = W'(d);
      tick();
      wr = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_pend();
      int k = 0;
      do begin tick(); k++; end while (!pend && k < 300);
      check("pend_seen", 32'(pend), 1);
   endtask

   task automatic run_to_cnt(input int v);
      int k = 0;
      while (m_cnt != v && k < 300) begin tick(); k++; end
      check("reach_cnt", 32'(m_cnt), 32'(v));
   endtask

   initial begin
      int last, hi, hi1, periods, k;
      rst = 1'b1; en = 1'b0; wr = 1'b0; fade = 1'b0; wr_ch = '0; wr_duty = '0;
      m_reset();
      #2;
      check("reset_led", 32'(led), 0);
      check("reset_pend", 32'(pend), 0);
      check("reset_busy", 32'(busy), 0);
      @(negedge clk); rst = 1'b0;
      // Idle run: LEDs dark, period pulses spaced MAX cycles.
      en = 1'b1; last = -1;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (pend) begin
            if (last >= 0) check("pend_spacing", 32'(i - last), MAX);
            last = i;
         end
      end
      // Jump mode.
      write(0, 64); write(1, 255);
      wait_pend();
      check("jump_busy", 32'(busy), 0);
      hi = 0; hi1 = 0;
      for (int i = 0; i < MAX; i++) begin tick(); hi += int'(led[0]); hi1 += int'(led[1]); end
      check("ch0_high", 32'(hi), 64);
      check("ch1_high", 32'(hi1), MAX);
      // Fade up and back down.
      fade = 1'b1;
      for (int d = 0; d < 2; d++) begin
         write(2, d ? 0 : 10);
         periods = 0; k = 0;
         while (busy && k < 50 * MAX) begin tick(); periods += int'(pend); k++; end
         check("fade_periods", 32'(periods), 40);
      end
      // Write landing exactly on the wrap edge.
      fade = 1'b0;
      run_to_cnt(MAX - 1);
      write(3, 100);
      check("wrap_write_busy", 32'(busy), 1);
      hi = 0; for (int i = 0; i < MAX; i++) begin tick(); hi += int'(led[3]); end
      check("ch3_old_period", 32'(hi), 0);
      hi = 0; for (int i = 0; i < MAX; i++) begin tick(); hi += int'(led[3]); end
      check("ch3_new_period", 32'(hi), 100);
      write(7, 200);
      check("bad_ch_busy", 32'(busy), 0);
      // Enable freeze mid-period.
      write(0, 128);
      run(2 * MAX);
      run_to_cnt(50);
      en = 1'b0;
      hi = 0; for (int i = 0; i < 20; i++) begin tick(); hi += int'(led[0]); end
      check("frozen_high", 32'(hi), 0);
      check("frozen_cnt", 32'(m_cnt), 50);
      en = 1'b1; hi = 0; k = 0;
      do begin tick(); hi += int'(led[0]); k++; end while (!pend && k < 300);
      check("resume_high", 32'(hi), 78);
      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         wr = ($urandom_range(0, 9) < 3); wr_ch = 3'($urandom_range(0, 7)); wr_duty = W'($urandom);
         if ($urandom_range(0, 199) == 0) fade = ~fade;
         en = ($urandom_range(0, 19) != 0);
         tick();
      end
      wr = 1'b0; en = 1'b1;
      // Async reset mid-fade.
      fade = 1'b1;
      write(4, 200); write(5, 255);
      run(3 * MAX);
      #2 rst = 1'b1;
      #1;
      check("async_led", 32'(led), 0);
      check("async_pend", 32'(pend), 0);
      check("async_busy", 32'(busy), 0);
      m_reset();
      #1 rst = 1'b0;
      hi = 0; for (int i = 0; i < 300; i++) begin tick(); hi += int'(|led); end
      check("post_reset_dark", 32'(hi), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
